// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotating one-hot row drive, press/release debounce, one code per press.
// Latency: 2-cycle column sync, then SETTLE_CYC per row and DEBOUNCE_CYC stable cycles to accept.
// Backpressure: one key is held until key_ready; a key accepted while one is pending is dropped and flagged on overflow.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC   = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] col_in,
  output logic [3:0] fila,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);

  localparam int MAXC = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    col_m;
  logic [3:0]    col_s;
  logic [1:0]    r_q;
  logic [1:0]    c_q;
  logic [1:0]    row_idx;
  logic [1:0]    low_col;
  logic          col_hit;
  logic          at_deb_last;
  logic          take;
  logic          room;

  always_comb begin
    row_idx = 2'd0;
    case (fila)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  // Lowest-numbered active column wins when several are seen together.
  always_comb begin
    low_col = 2'd0;
    if (col_s[0])      low_col = 2'd0;
    else if (col_s[1]) low_col = 2'd1;
    else if (col_s[2]) low_col = 2'd2;
    else if (col_s[3]) low_col = 2'd3;
  end

  assign col_hit     = col_s[c_q];
  assign at_deb_last = (cnt == DEB_LAST);
  assign take        = (state == ST_DEB) && col_hit && at_deb_last;
  assign room        = !key_valid || key_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m     <= 4'd0;
      col_s     <= 4'd0;
      state     <= ST_SCAN;
      cnt       <= '0;
      fila      <= 4'b0001;
      r_q       <= 2'd0;
      c_q       <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      col_m    <= col_in;
      col_s    <= col_m;
      overflow <= 1'b0;

      if (key_valid && key_ready) key_valid <= 1'b0;
      // A fresh key overrides the drop above when the old one is consumed this same cycle.
      if (take) begin
        if (room) begin
          key_code  <= {r_q, c_q};
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      case (state)
        ST_SCAN: begin
          if (scan_en) begin
            if (cnt == SET_LAST) begin
              cnt <= '0;
              if (col_s == 4'd0) begin
                fila <= {fila[2:0], fila[3]};
              end else begin
                r_q   <= row_idx;
                c_q   <= low_col;
                state <= ST_DEB;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_DEB: begin
          if (!col_hit) begin
            cnt   <= '0;
            fila  <= {fila[2:0], fila[3]};
            state <= ST_SCAN;
          end else if (at_deb_last) begin
            cnt   <= '0;
            state <= ST_REL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_REL: begin
          if (col_hit) begin
            cnt <= '0;
          end else if (at_deb_last) begin
            cnt   <= '0;
            fila  <= {fila[2:0], fila[3]};
            state <= ST_SCAN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model driven by the row lines, a per-cycle reference model, and directed scenarios.
module tb_keypad_scan_ctrl;

  localparam int SET = 4;
  localparam int DEB = 8;

  localparam int PH_SCAN  = 0;
  localparam int PH_PRESS = 1;
  localparam int PH_LIFT  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] col_in;
  logic [3:0] fila;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SETTLE_CYC(SET), .DEBOUNCE_CYC(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_en   (scan_en),
    .col_in    (col_in),
    .fila      (fila),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Stimulus knobs: which keys are held down (column mask per row) and consumer behaviour.
  logic [3:0] keys [4];
  logic       rst_v;
  logic       scan_en_v;
  logic       ready_v;
  logic       ready_on_accept;

  // Reference model state.
  int         m_row, m_mode, m_cnt, m_r, m_c;
  logic       m_valid, m_ovf;
  logic [3:0] m_code, m_s1, m_s2;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] m_fila();
    logic [3:0] one;
    one = 4'b0001;
    return one << m_row;
  endfunction

  function automatic bit m_accepting();
    return (m_mode == PH_PRESS) && m_s2[m_c] && (m_cnt + 1 == DEB);
  endfunction

  task automatic model_reset();
    m_row = 0; m_mode = PH_SCAN; m_cnt = 0; m_r = 0; m_c = 0;
    m_valid = 1'b0; m_ovf = 1'b0; m_code = 4'd0; m_s1 = 4'd0; m_s2 = 4'd0;
  endtask

  task automatic model_advance(input logic r_n, input logic se, input logic [3:0] ci, input logic rdy);
    bit hit, acc, was_valid;
    if (!r_n) begin
      model_reset();
      return;
    end
    hit       = m_s2[m_c];
    acc       = m_accepting();
    was_valid = m_valid;
    m_ovf     = 1'b0;
    if (was_valid && rdy) m_valid = 1'b0;
    if (acc) begin
      if (!was_valid || rdy) begin
        m_code  = 4'(m_r * 4 + m_c);
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    case (m_mode)
      PH_SCAN: if (se) begin
        if (m_cnt == SET - 1) begin
          m_cnt = 0;
          if (m_s2 == 4'd0) m_row = (m_row + 1) % 4;
          else begin
            m_r = m_row;
            m_c = 3;
            for (int b = 3; b >= 0; b--) if (m_s2[b]) m_c = b;
            m_mode = PH_PRESS;
          end
        end else m_cnt++;
      end
      PH_PRESS: begin
        if (!hit) begin m_cnt = 0; m_row = (m_row + 1) % 4; m_mode = PH_SCAN; end
        else if (acc) begin m_cnt = 0; m_mode = PH_LIFT; end
        else m_cnt++;
      end
      default: begin
        if (hit) m_cnt = 0;
        else if (m_cnt + 1 == DEB) begin m_cnt = 0; m_row = (m_row + 1) % 4; m_mode = PH_SCAN; end
        else m_cnt++;
      end
    endcase
    m_s2 = m_s1;
    m_s1 = ci;
  endtask

  // One clock: drive inputs in the low phase, advance the model, then compare just after the next negedge.
  task automatic step();
    logic [3:0] ci;
    logic       rdy;
    ci  = keys[m_row];
    rdy = ready_on_accept ? logic'(m_accepting()) : ready_v;
    rst       = rst_v;
    scan_en   = scan_en_v;
    col_in    = ci;
    key_ready = rdy;
    model_advance(rst_v, scan_en_v, ci, rdy);
    @(negedge clk);
    chk("fila", fila, m_fila());
    chk("key_code", key_code, m_code);
    chk("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
    chk("overflow", {3'b000, overflow}, {3'b000, m_ovf});
  endtask

  function automatic bit cond(input int what);
    case (what)
      0:       return m_valid;
      1:       return m_mode == PH_SCAN;
      2:       return m_ovf;
      3:       return (m_mode == PH_PRESS) && (m_cnt == 3);
      4:       return (m_row == 0) && (m_mode == PH_SCAN) && (m_cnt == 0);
      default: return m_code == 4'd15;
    endcase
  endfunction

  task automatic run_until(input string name, input int what, input int limit);
    int n;
    n = 0;
    while (!cond(what) && n < limit) begin
      step();
      n++;
    end
    check_cnt++;
    if (cond(what)) pass_cnt++;
    else $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", name, n, limit);
  endtask

  initial begin
    logic [3:0] exp_f;
    logic [3:0] one;
    logic [3:0] f0;
    one = 4'b0001;
    for (int i = 0; i < 4; i++) keys[i] = 4'd0;
    rst = 1'b0; scan_en = 1'b1; col_in = 4'd0; key_ready = 1'b0;
    rst_v = 1'b0; scan_en_v = 1'b1; ready_v = 1'b0; ready_on_accept = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset state and ring rotation.
    repeat (3) step();
    chk("rst_fila", fila, 4'b0001);
    chk("rst_code", key_code, 4'd0);
    chk("rst_valid", {3'b000, key_valid}, 4'd0);
    chk("rst_ovf", {3'b000, overflow}, 4'd0);
    rst_v = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      step();
      exp_f = one << ((n / 4) % 4);
      chk("ring", fila, exp_f);
    end

    // Bounce on row 0: five cycles of contact, no key.
    run_until("row0_start", 4, 40);
    keys[0] = 4'b0001;
    repeat (5) step();
    keys[0] = 4'b0000;
    repeat (3) step();
    chk("bounce_fila", fila, 4'b0010);
    chk("bounce_valid", {3'b000, key_valid}, 4'd0);
    chk("bounce_ovf", {3'b000, overflow}, 4'd0);

    // Press row 2 col 1, then release.
    keys[2] = 4'b0010;
    run_until("press9", 0, 60);
    chk("press9_code", key_code, 4'd9);
    chk("press9_valid", {3'b000, key_valid}, 4'd1);
    chk("press9_fila", fila, 4'b0100);
    keys[2] = 4'b0000;
    repeat (9) step();
    chk("release_hold", fila, 4'b0100);
    step();
    chk("release_next", fila, 4'b1000);

    // Handshake: hold off, then one-cycle ready.
    repeat (20) step();
    chk("hold_valid", {3'b000, key_valid}, 4'd1);
    chk("hold_code", key_code, 4'd9);
    ready_v = 1'b1;
    step();
    ready_v = 1'b0;
    chk("consume", {3'b000, key_valid}, 4'd0);

    // scan_en low freezes the ring.
    scan_en_v = 1'b0;
    f0 = m_fila();
    repeat (10) step();
    chk("freeze", fila, f0);
    scan_en_v = 1'b1;

    // Overflow: key 9 pending, press row 3 col 3.
    keys[2] = 4'b0010;
    run_until("repress9", 0, 60);
    keys[2] = 4'b0000;
    run_until("lift9", 1, 40);
    keys[3] = 4'b1000;
    run_until("ovf", 2, 60);
    chk("ovf_pulse", {3'b000, overflow}, 4'd1);
    chk("ovf_code", key_code, 4'd9);
    chk("ovf_valid", {3'b000, key_valid}, 4'd1);
    step();
    chk("ovf_once", {3'b000, overflow}, 4'd0);
    keys[3] = 4'b0000;
    run_until("lift15a", 1, 40);

    // Same press with ready exactly on the acceptance cycle.
    ready_on_accept = 1'b1;
    keys[3] = 4'b1000;
    run_until("press15", 5, 60);
    chk("swap_code", key_code, 4'd15);
    chk("swap_valid", {3'b000, key_valid}, 4'd1);
    chk("swap_ovf", {3'b000, overflow}, 4'd0);
    ready_on_accept = 1'b0;
    keys[3] = 4'b0000;
    run_until("lift15b", 1, 40);

    // Multi-column on row 0 picks the lowest column.
    ready_v = 1'b1;
    step();
    ready_v = 1'b0;
    keys[0] = 4'b0110;
    run_until("press1", 0, 60);
    chk("multi_code", key_code, 4'd1);
    keys[0] = 4'b0000;
    run_until("lift1", 1, 40);

    // Asynchronous reset in the middle of a debounce with a key pending.
    keys[2] = 4'b0001;
    run_until("mid_deb", 3, 60);
    chk("pre_rst_fila", fila, 4'b0100);
    chk("pre_rst_valid", {3'b000, key_valid}, 4'd1);
    rst_v = 1'b0;
    rst   = 1'b0;
    #1;
    chk("arst_fila", fila, 4'b0001);
    chk("arst_valid", {3'b000, key_valid}, 4'd0);
    chk("arst_code", key_code, 4'd0);
    model_reset();
    keys[2] = 4'b0000;
    repeat (2) step();
    rst_v = 1'b1;
    repeat (12) step();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
